lsu_mem_if: RTL and testbench

- Load/store unit that sits directly upstream of the data BRAM (32-bit words, byte write enables, 1-cycle registered read).
- Accepts one byte-addressed RV32I load/store request per handshake from the execute stage.
- Translates the request into BRAM word address, byte enables and lane-replicated write data.
- Tracks the 1-cycle read latency, then returns aligned, sign/zero-extended load data to writeback.

---
 rtl/lsu_mem_if.sv | 191 +++++++++++++++++++
 tb/tb_lsu_mem_if.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lsu_mem_if                                                   |
// | Description : RV32I load/store unit in front of a 32-bit data BRAM with    |
// |               byte enables and a 1-cycle registered read. Converts byte    |
// |               requests to word index, byte enables and lane-replicated     |
// |               write data; formats load data with sign/zero extension.      |
// | Options     : LSU_MISALIGN_TRAP_EN - report misaligned H/W accesses        |
// |               instead of truncating the address to natural alignment.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lsu_mem_if #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        resp_misaligned,
  output logic [31:0] mem_r_addr,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic [3:0]  mem_w_enable,
  output logic [31:0] mem_row_addr,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_r_data
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_LOAD_WAIT = 2'd1;
  localparam logic [1:0]  S_RESP      = 2'd2;

  // Byte span of the BRAM window; one bit wider than needed so it cannot wrap.
  localparam logic [33:0] C_LIMIT = 34'(MEM_WORDS) << 2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        mis_q, mis_d;

  logic        accept;
  logic [31:0] offset;
  logic        legal;
  logic        fault;
  logic        mis;
  logic        err;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_fmt;

  // Request decode: range/legality checks, lane, byte enables and BRAM drive.
  always_comb begin
    accept = req_valid && req_ready;
    offset = req_addr - BASE_ADDR;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
    // An address below BASE_ADDR wraps to a huge offset and lands out of range.
    fault = !legal || !({2'b00, offset} < C_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = legal && (((req_funct3[1:0] == 2'b01) && offset[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (offset[1:0] != 2'b00)));
`else
    mis = 1'b0;
`endif
    err = fault || mis;
    // Lane of the lowest accessed byte; halves/words are forced to natural alignment.
    case (req_funct3[1:0])
      2'b00: begin
        lane      = offset[1:0];
        be        = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane      = {offset[1], 1'b0};
        be        = 4'b0011 << lane;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        lane      = 2'b00;
        be        = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase
    mem_r_addr   = {2'b00, offset[31:2]};
    mem_w_addr   = {2'b00, offset[31:2]};
    mem_w_data   = wdata_rep;
    mem_w_enable = (accept && req_we && !err && !rst) ? be : 4'b0000;
    mem_row_addr = req_addr;
    mem_pc       = req_pc;
  end

  // Load formatting of the BRAM read word using the offset/funct3 captured at accept.
  always_comb begin
    case (lane_q)
      2'd0:    sel_byte = mem_r_data[7:0];
      2'd1:    sel_byte = mem_r_data[15:8];
      2'd2:    sel_byte = mem_r_data[23:16];
      default: sel_byte = mem_r_data[31:24];
    endcase
    sel_half = lane_q[1] ? mem_r_data[31:16] : mem_r_data[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_fmt = {24'h0, sel_byte};
      3'b001:  load_fmt = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_fmt = {16'h0, sel_half};
      default: load_fmt = mem_r_data;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_d = (req_we || err) ? S_RESP : S_LOAD_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_WAIT: state_d = flush ? S_IDLE : S_RESP;
      default:     state_d = S_IDLE;
    endcase
  end

  // Response datapath next values: capture flags at accept, load data one cycle later.
  always_comb begin
    lane_d  = lane_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    mis_d   = mis_q;
    if (accept) begin
      lane_d  = lane;
      f3_d    = req_funct3;
      rdata_d = 32'h0;
      fault_d = fault;
      mis_d   = mis;
    end else if (state_q == S_LOAD_WAIT) begin
      rdata_d = load_fmt;
    end
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= 2'b00;
      f3_q    <= 3'b000;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs: response fields are only non-zero during the single valid pulse.
  always_comb begin
    req_ready       = (state_q != S_LOAD_WAIT);
    resp_valid      = (state_q == S_RESP) && !flush;
    resp_rdata      = resp_valid ? rdata_q : 32'h0;
    resp_fault      = resp_valid && fault_q;
    resp_misaligned = resp_valid && mis_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lsu_mem_if                                                |
// | Description : Self-checking bench for lsu_mem_if: directed vector table,   |
// |               multi-cycle corner sequences and randomized requests checked |
// |               against a byte-level memory model.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lsu_mem_if;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WORDS = 32768;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        req_ready, resp_valid, resp_fault, resp_misaligned;
  logic [31:0] resp_rdata, mem_r_addr, mem_w_addr, mem_w_data, mem_row_addr, mem_pc;
  logic [3:0]  mem_w_enable;
  logic [31:0] mem_r_data = 32'h0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  lsu_mem_if #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_misaligned(resp_misaligned),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_w_enable(mem_w_enable), .mem_row_addr(mem_row_addr), .mem_pc(mem_pc),
    .mem_r_data(mem_r_data)
  );

  // BRAM environment: byte-enabled write, registered read (read-before-write).
  logic [31:0] bram [int];
  always @(posedge clk) begin : bram_model
    logic [31:0] w;
    int ridx, widx;
    ridx = int'(mem_r_addr);
    if (mem_r_addr < WORDS && bram.exists(ridx)) mem_r_data <= bram[ridx];
    else mem_r_data <= 32'h0;
    if (mem_w_enable != 4'b0000 && mem_w_addr < WORDS) begin
      widx = int'(mem_w_addr);
      w = bram.exists(widx) ? bram[widx] : 32'h0;
      for (int i = 0; i < 4; i++) if (mem_w_enable[i]) w[8*i +: 8] = mem_w_data[8*i +: 8];
      bram[widx] = w;
    end
  end

  always @(negedge clk) if (resp_valid === 1'b1) pulses++;

  // Reference: byte-addressed memory image, updated from the architectural rules.
  logic [7:0] ref_bytes [int];

  function automatic logic [7:0] rd_byte(input int a);
    return ref_bytes.exists(a) ? ref_bytes[a] : 8'h00;
  endfunction

  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output bit e_fault, output bit e_mis,
                                output logic [31:0] e_rdata, output logic [3:0] e_be,
                                output logic [31:0] e_wdata, output int e_lat);
    logic [31:0] off, a, val, mask;
    int n, lo;
    bit legal;
    off   = addr - BASE;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n     = 1 << f3[1:0];
    e_fault = !legal || (off >= 32'(4 * WORDS));
    e_mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    e_mis = legal && (n > 1) && ((off % 32'(n)) != 0);
`endif
    a       = off - (off % 32'(n));
    lo      = int'(a % 4);
    e_rdata = 32'h0;
    e_be    = 4'b0000;
    e_wdata = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
    if (e_fault || e_mis) begin
      e_lat = 1;
    end else if (we) begin
      e_lat = 1;
      for (int i = 0; i < n; i++) begin
        ref_bytes[int'(a) + i] = wd[8*i +: 8];
        e_be[lo + i] = 1'b1;
      end
    end else begin
      e_lat = 2;
      val = 32'h0;
      for (int i = 0; i < n; i++) val = val | (32'(rd_byte(int'(a) + i)) << (8 * i));
      if (!f3[2] && n < 4) begin
        mask = (32'h1 << (8 * n)) - 32'h1;
        if (val[8*n-1]) val = val | ~mask;
      end
      e_rdata = val;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request starting at a negedge; returns at the negedge of its response cycle.
  task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input bit e_fault, input bit e_mis,
                      input logic [31:0] e_rdata, input logic [3:0] e_be,
                      input logic [31:0] e_wdata, input int e_lat, input bit fl,
                      input string tag);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_pc = $urandom; flush = fl;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'h1);
    chk({tag, ".wen"}, 32'(mem_w_enable), 32'(e_be));
    chk({tag, ".raddr"}, mem_r_addr, (addr - BASE) >> 2);
    chk({tag, ".pc"}, mem_pc, req_pc);
    if (e_be != 4'b0000) begin
      chk({tag, ".waddr"}, mem_w_addr, (addr - BASE) >> 2);
      chk({tag, ".wdata"}, mem_w_data, e_wdata);
      chk({tag, ".row"}, mem_row_addr, addr);
    end
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    if (e_lat == 2) begin
      chk({tag, ".wait_valid"}, 32'(resp_valid), 32'h0);
      chk({tag, ".wait_ready"}, 32'(req_ready), 32'h0);
      @(negedge clk);
      #1;
    end
    chk({tag, ".valid"}, 32'(resp_valid), 32'h1);
    chk({tag, ".fault"}, 32'(resp_fault), 32'(e_fault));
    chk({tag, ".mis"}, 32'(resp_misaligned), 32'(e_mis));
    chk({tag, ".rdata"}, resp_rdata, e_rdata);
  endtask

  // Model-driven request (expected values from the reference model).
  task automatic mreq(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input bit fl, input string tag);
    bit ef, em; logic [31:0] er, ew; logic [3:0] eb; int el;
    model(we, f3, addr, wd, ef, em, er, eb, ew, el);
    xact(we, f3, addr, wd, ef, em, er, eb, ew, el, fl, tag);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          fault;
    bit          mis;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ef, em; logic [31:0] er, ew; logic [3:0] eb; int el, lat, p0, k;
    logic [2:0] f3r; logic [31:0] ar;

    tbl[0]  = '{1'b1, 3'b010, 32'h100,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 3'b010, 32'h100,   32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0};
    tbl[2]  = '{1'b1, 3'b000, 32'h103,   32'h000000A5, 1'b0, 1'b0, 32'h0, 4'b1000, 32'hA5A5A5A5};
    tbl[3]  = '{1'b0, 3'b000, 32'h103,   32'h0, 1'b0, 1'b0, 32'hFFFFFFA5, 4'h0, 32'h0};
    tbl[4]  = '{1'b0, 3'b100, 32'h103,   32'h0, 1'b0, 1'b0, 32'h000000A5, 4'h0, 32'h0};
    tbl[5]  = '{1'b1, 3'b001, 32'h102,   32'h00008001, 1'b0, 1'b0, 32'h0, 4'b1100, 32'h80018001};
    tbl[6]  = '{1'b0, 3'b001, 32'h102,   32'h0, 1'b0, 1'b0, 32'hFFFF8001, 4'h0, 32'h0};
    tbl[7]  = '{1'b0, 3'b101, 32'h102,   32'h0, 1'b0, 1'b0, 32'h00008001, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 3'b010, 32'h20000, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[9]  = '{1'b0, 3'b010, 32'h100,   32'h0, 1'b0, 1'b0, 32'h8001BEEF, 4'h0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[10] = '{1'b0, 3'b010, 32'h102,   32'h0, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0};
`else
    tbl[10] = '{1'b0, 3'b010, 32'h102,   32'h0, 1'b0, 1'b0, 32'h8001BEEF, 4'h0, 32'h0};
`endif
    tbl[11] = '{1'b1, 3'b100, 32'h100,   32'h12345678, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[12] = '{1'b0, 3'b011, 32'h100,   32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[13] = '{1'b1, 3'b000, 32'h1FFFF, 32'h0000007F, 1'b0, 1'b0, 32'h0, 4'b1000, 32'h7F7F7F7F};
    tbl[14] = '{1'b0, 3'b000, 32'h1FFFF, 32'h0, 1'b0, 1'b0, 32'h0000007F, 4'h0, 32'h0};
    tbl[15] = '{1'b1, 3'b001, 32'h20000, 32'h0000BEEF, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0};
    tbl[16] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[17] = '{1'b1, 3'b001, 32'h105,   32'h00001234, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0};
    tbl[18] = '{1'b0, 3'b101, 32'h104,   32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0};
`else
    tbl[17] = '{1'b1, 3'b001, 32'h105,   32'h00001234, 1'b0, 1'b0, 32'h0, 4'b0011, 32'h12341234};
    tbl[18] = '{1'b0, 3'b101, 32'h104,   32'h0, 1'b0, 1'b0, 32'h00001234, 4'h0, 32'h0};
`endif

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset.valid", 32'(resp_valid), 32'h0);
    chk("reset.ready", 32'(req_ready), 32'h1);
    chk("reset.rdata", resp_rdata, 32'h0);
    chk("reset.fault", 32'(resp_fault), 32'h0);
    chk("reset.wen", 32'(mem_w_enable), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table (memory image kept in step through the model).
    for (int i = 0; i < NV; i++) begin
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, ef, em, er, eb, ew, el);
      lat = (tbl[i].we || tbl[i].fault || tbl[i].mis) ? 1 : 2;
      xact(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].fault, tbl[i].mis,
           tbl[i].rdata, tbl[i].be, tbl[i].wdata, lat, 1'b0, $sformatf("vec%0d", i));
    end

    // Back-to-back LW then SW accepted in RESP: exactly two pulses.
    repeat (2) @(negedge clk);
    p0 = pulses;
    mreq(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, "b2b.lw");
    mreq(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 1'b0, "b2b.sw");
    repeat (3) @(negedge clk);
    chk("b2b.pulses", 32'(pulses - p0), 32'h2);
    mreq(1'b0, 3'b010, 32'h104, 32'h0, 1'b0, "b2b.readback");

    // flush asserted in IDLE together with a load accept has no effect.
    repeat (2) @(negedge clk);
    mreq(1'b0, 3'b001, 32'h106, 32'h0, 1'b1, "flush_idle");

    // flush during LOAD_WAIT: no response, ready again next cycle.
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_lw.valid0", 32'(resp_valid), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_lw.valid1", 32'(resp_valid), 32'h0);
    chk("flush_lw.ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("flush_lw.valid2", 32'(resp_valid), 32'h0);

    // flush during RESP of a store: pulse suppressed, write still lands.
    model(1'b1, 3'b010, 32'h108, 32'h0BADC0DE, ef, em, er, eb, ew, el);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h108;
    req_wdata = 32'h0BADC0DE;
    #1 chk("flush_resp.wen", 32'(mem_w_enable), 32'hF);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_resp.valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_resp.after", 32'(resp_valid), 32'h0);
    mreq(1'b0, 3'b010, 32'h108, 32'h0, 1'b0, "flush_resp.readback");

    // Reset during LOAD_WAIT, then a store offered while reset is held.
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10C;
    req_wdata = 32'h55AA55AA;
    #1;
    chk("rst.valid", 32'(resp_valid), 32'h0);
    chk("rst.rdata", resp_rdata, 32'h0);
    chk("rst.fault", 32'(resp_fault), 32'h0);
    chk("rst.mis", 32'(resp_misaligned), 32'h0);
    chk("rst.ready", 32'(req_ready), 32'h1);
    chk("rst.wen", 32'(mem_w_enable), 32'h0);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;
    #1 chk("rst.after_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    mreq(1'b0, 3'b010, 32'h10C, 32'h0, 1'b0, "rst.no_write");

    // Randomized requests against the reference model.
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0: f3r = 3'b000; 1: f3r = 3'b001; 2: f3r = 3'b010; 3: f3r = 3'b100;
        default: f3r = 3'b101;
      endcase
      if (k == 0) f3r = 3'($urandom);
      if (k == 1) ar = $urandom;
      else if (k == 2) ar = 32'h1FFF8 + 32'($urandom_range(0, 15));
      else ar = 32'($urandom_range(0, 255));
      mreq(1'($urandom), f3r, ar, $urandom, 1'b0, $sformatf("rnd%0d", n));
      k = int'($urandom_range(0, 3));
      if (k > 0) begin
        @(negedge clk);
        chk($sformatf("rnd%0d.single_pulse", n), 32'(resp_valid), 32'h0);
        repeat (k - 1) @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
